// File: rtl/tt_uio_host_port.sv
`default_nettype none
// ============================================================================
// Module      : tt_uio_host_port
// Description : Board-side host engine for the Tiny Tapeout 8-bit uio bus.
//               Runs single-byte read/write commands as a four-phase
//               strobe/acknowledge handshake. It also owns bus direction and
//               inserts turnaround dead time whenever the direction changes.
//               Optional feature macro: TT_UIO_HOST_TIMEOUT_EN adds an
//               acknowledge timeout that completes the transfer with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_uio_host_port #(
    parameter int TURN_CYCLES = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    inout  wire  [7:0] uio_inout,
    output logic       bus_dir,
    output logic       bus_stb,
    input  logic       bus_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TURN   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACK_HI = 3'd3;
    localparam logic [2:0] S_ACK_LO = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Last cycle index of the turnaround window (counter starts at 0 on entry).
    localparam logic [7:0] c_TURN_LAST = 8'(TURN_CYCLES - 1);
`ifdef TT_UIO_HOST_TIMEOUT_EN
    // Last cycle index allowed in an acknowledge phase before giving up.
    localparam logic [7:0] c_ACK_LAST  = 8'(ACK_TIMEOUT - 1);
`endif

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic       r_sync1;
    logic       r_ack_s;
    logic       r_write;
    logic [7:0] r_wdata;
    logic [7:0] r_rsp_data;
    logic       r_bus_dir;
    logic       r_oe;
    logic       w_expired;
    logic       w_timeout;
    logic       w_cnt_run;

    // Handshake outputs are pure decodes of the current state.
    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign bus_stb   = (r_state == S_ACK_HI);
    assign bus_dir   = r_bus_dir;
    assign rsp_data  = r_rsp_data;
    assign uio_inout = r_oe ? r_wdata : 8'bzzzz_zzzz;

    assign w_cnt_run = (r_state == S_TURN) || (r_state == S_ACK_HI) || (r_state == S_ACK_LO);

`ifdef TT_UIO_HOST_TIMEOUT_EN
    assign w_expired = (r_cnt == c_ACK_LAST);
`else
    assign w_expired = 1'b0;
`endif

    // Two-flop synchronizer for the project acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_ack_s <= 1'b0;
        end else begin
            r_sync1 <= bus_ack;
            r_ack_s <= r_sync1;
        end
    end

    // Next-state decode; w_timeout flags an acknowledge phase that ran out.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    // write needs bus_dir=1, read needs bus_dir=0
                    w_state_nxt = (cmd_write == r_bus_dir) ? S_SETUP : S_TURN;
                end
            end
            S_TURN: begin
                if (r_cnt == c_TURN_LAST) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACK_HI;
            end
            S_ACK_HI: begin
                if (r_ack_s) begin
                    w_state_nxt = S_ACK_LO;
                end else if (w_expired) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_ACK_LO: begin
                if (!r_ack_s) begin
                    w_state_nxt = S_DONE;
                end else if (w_expired) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and the phase counter, which restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= 8'd0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Command capture, bus direction / output enable sequencing and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_wdata    <= 8'd0;
            r_rsp_data <= 8'd0;
            r_bus_dir  <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_write    <= cmd_write;
                        r_wdata    <= cmd_wdata;
                        r_rsp_data <= 8'd0;
                        if (cmd_write != r_bus_dir) begin
                            // Acquire: claim direction now, drive after the dead time.
                            // Release: stop driving now, hand direction over after it.
                            if (cmd_write) begin
                                r_bus_dir <= 1'b1;
                            end else begin
                                r_oe <= 1'b0;
                            end
                        end else if (cmd_write) begin
                            r_oe <= 1'b1;
                        end
                    end
                end
                S_TURN: begin
                    if (w_state_nxt == S_SETUP) begin
                        if (r_write) begin
                            r_oe <= 1'b1;
                        end else begin
                            r_bus_dir <= 1'b0;
                        end
                    end
                end
                S_ACK_HI: begin
                    if (r_ack_s && !r_write) begin
                        r_rsp_data <= uio_inout;
                    end
                end
                default: begin
                end
            endcase
            // Give up the pins on timeout; direction is left where it is.
            if (w_timeout) begin
                r_oe       <= 1'b0;
                r_rsp_data <= 8'd0;
            end
        end
    end

`ifdef TT_UIO_HOST_TIMEOUT_EN
    logic r_rsp_err;

    // Error flag: cleared on accept, set when an acknowledge phase times out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end else if (cmd_ready && cmd_valid) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_uio_host_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_uio_host_port
// Description : Directed, table-driven bench for tt_uio_host_port with a
//               behavioural project-side responder on the uio pins.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tt_uio_host_port;

    localparam int TURN = 4;
    localparam int TMO  = 10;
    localparam int D    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_write;
    logic [7:0] cmd_wdata;
    wire        cmd_ready;
    wire        rsp_valid;
    wire  [7:0] rsp_data;
    wire        rsp_err;
    wire        bus_dir;
    wire        bus_stb;
    logic       bus_ack;
    wire  [7:0] uio;

    logic       resp_oe;
    logic [7:0] resp_drv;
    logic       resp_en;
    logic [7:0] resp_byte;
    logic [7:0] resp_cap;
    int         stb_seen;

    int checks = 0;
    int errors = 0;
    int rsp_pulses = 0;
    int dir_viol = 0;
    int n_cmds = 0;

    assign uio = resp_oe ? resp_drv : 8'bzzzz_zzzz;

    tt_uio_host_port #(.TURN_CYCLES(TURN), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .uio_inout(uio), .bus_dir(bus_dir), .bus_stb(bus_stb), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Project-side responder: ack D cycles into the strobe, drop ack once strobe falls.
    initial begin
        bus_ack = 1'b0; resp_oe = 1'b0; resp_drv = 8'd0; stb_seen = 0; resp_cap = 8'd0;
        forever begin
            @(negedge clk);
            if (rst || !resp_en) begin
                bus_ack = 1'b0; resp_oe = 1'b0; stb_seen = 0;
            end else begin
                if (bus_stb && !bus_ack) begin
                    stb_seen++;
                    if (stb_seen >= D) begin
                        bus_ack = 1'b1;
                        if (bus_dir) resp_cap = uio;
                    end
                end else if (!bus_stb && bus_ack) begin
                    bus_ack = 1'b0; stb_seen = 0;
                end
                resp_drv = resp_byte;
                resp_oe  = !bus_dir && (bus_stb || bus_ack);
            end
        end
    end

    // Bus monitor: count completions and any host drive while the project owns the pins.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) rsp_pulses++;
            if (!bus_dir && dut.r_oe) dir_viol++;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic wr, input logic [7:0] wd, input bit hold,
                          output int lat, output logic [7:0] data, output logic err,
                          output int dir_cyc, output int oe_cyc, output int stb_cyc,
                          output logic rdy0);
        logic dir0, oe0;
        bit done;
        @(negedge clk);
        rdy0 = cmd_ready; dir0 = bus_dir; oe0 = dut.r_oe;
        cmd_valid = 1'b1; cmd_write = wr; cmd_wdata = wd;
        n_cmds++;
        lat = 0; dir_cyc = -1; oe_cyc = -1; stb_cyc = 0; done = 1'b0; data = 8'd0; err = 1'b0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (!hold) cmd_valid = 1'b0;
            else cmd_wdata = wd ^ 8'(lat | 1);
            if (dir_cyc < 0 && bus_dir != dir0) dir_cyc = lat;
            if (oe_cyc < 0 && dut.r_oe != oe0) oe_cyc = lat;
            if (bus_stb) stb_cyc++;
            if (rsp_valid) begin
                done = 1'b1; data = rsp_data; err = rsp_err;
            end
        end
        cmd_valid = 1'b0;
        if (!done) chk("rsp_seen", 0, 1);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic [7:0] rb;
        int         lat;
        logic [7:0] data;
        logic       dir;
        int         dir_cyc;
        int         oe_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, dc, oc, sc, pulses0, k;
        logic [7:0] d;
        logic e, r0;
        bit seen;

        vecs[0] = '{1'b1, 8'hA5, 8'h00, 15, 8'h00, 1'b1,  1,  5};
        vecs[1] = '{1'b1, 8'h5A, 8'h00, 11, 8'h00, 1'b1, -1, -1};
        vecs[2] = '{1'b0, 8'h00, 8'h3C, 15, 8'h3C, 1'b0,  5,  1};
        vecs[3] = '{1'b0, 8'h00, 8'hC3, 11, 8'hC3, 1'b0, -1, -1};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 11, 8'hFF, 1'b0, -1, -1};
        vecs[5] = '{1'b1, 8'h00, 8'h77, 15, 8'h00, 1'b1,  1,  5};
        vecs[6] = '{1'b1, 8'hFF, 8'h00, 11, 8'h00, 1'b1, -1, -1};
        vecs[7] = '{1'b0, 8'h00, 8'h81, 15, 8'h81, 1'b0,  5,  1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = 8'd0;
        resp_en = 1'b1; resp_byte = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_bus_dir", int'(bus_dir), 0);
        chk("rst_bus_stb", int'(bus_stb), 0);
        chk("rst_oe", int'(dut.r_oe), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single transfers covering both directions and lazy turnaround.
        for (int i = 0; i < 8; i++) begin
            resp_byte = vecs[i].rb;
            resp_cap  = ~vecs[i].wd;
            do_cmd(vecs[i].wr, vecs[i].wd, 1'b0, lat, d, e, dc, oc, sc, r0);
            chk($sformatf("v%0d_ready", i), int'(r0), 1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rsp_data", i), int'(d), int'(vecs[i].data));
            chk($sformatf("v%0d_rsp_err", i), int'(e), 0);
            chk($sformatf("v%0d_bus_dir", i), int'(bus_dir), int'(vecs[i].dir));
            chk($sformatf("v%0d_dir_change_cyc", i), dc, vecs[i].dir_cyc);
            chk($sformatf("v%0d_oe_change_cyc", i), oc, vecs[i].oe_cyc);
            if (vecs[i].wr) chk($sformatf("v%0d_wr_captured", i), int'(resp_cap), int'(vecs[i].wd));
        end

        // Three back-to-back reads: each accepted the cycle after the previous response.
        for (int i = 0; i < 3; i++) begin
            resp_byte = 8'(8'h11 * (i + 1));
            do_cmd(1'b0, 8'h00, 1'b0, lat, d, e, dc, oc, sc, r0);
            chk($sformatf("b2b%0d_ready", i), int'(r0), 1);
            chk($sformatf("b2b%0d_latency", i), lat, 11);
            chk($sformatf("b2b%0d_rsp_data", i), int'(d), 8'h11 * (i + 1));
            chk($sformatf("b2b%0d_no_turn", i), dc, -1);
        end

        // cmd_valid held through a write with changing cmd_wdata.
        resp_cap = 8'h00;
        do_cmd(1'b1, 8'h96, 1'b1, lat, d, e, dc, oc, sc, r0);
        pulses0 = rsp_pulses;
        repeat (25) @(negedge clk);
        chk("hold_latency", lat, 15);
        chk("hold_wr_captured", int'(resp_cap), 8'h96);
        chk("hold_no_extra_rsp", rsp_pulses, pulses0);
        chk("hold_ready_after", int'(cmd_ready), 1);

        // Reset pulsed during ACK_LO of a write (bus already host-owned).
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 8'hB7;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 1'b0; k = 0;
        while (k < 100 && !(seen && !bus_stb)) begin
            if (bus_stb) seen = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("rstmid_reached_ack_lo", int'(seen && !bus_stb), 1);
        chk("rstmid_driving_before", int'(dut.r_oe), 1);
        pulses0 = rsp_pulses;
        #1 rst = 1'b1;
        #1;
        chk("rstmid_oe", int'(dut.r_oe), 0);
        chk("rstmid_bus_dir", int'(bus_dir), 0);
        chk("rstmid_cmd_ready", int'(cmd_ready), 1);
        chk("rstmid_bus_stb", int'(bus_stb), 0);
        chk("rstmid_rsp_valid", int'(rsp_valid), 0);
        chk("rstmid_rsp_data", int'(rsp_data), 0);
        chk("rstmid_rsp_err", int'(rsp_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstmid_no_rsp", rsp_pulses, pulses0);

`ifdef TT_UIO_HOST_TIMEOUT_EN
        // Silent project: write times out after TMO strobe cycles.
        resp_en = 1'b0;
        do_cmd(1'b1, 8'h4E, 1'b0, lat, d, e, dc, oc, sc, r0);
        chk("tmo_latency", lat, TURN + 2 + TMO);
        chk("tmo_stb_cycles", sc, TMO);
        chk("tmo_rsp_err", int'(e), 1);
        chk("tmo_rsp_data", int'(d), 0);
        @(negedge clk);
        chk("tmo_ready_next", int'(cmd_ready), 1);
        chk("tmo_oe_released", int'(dut.r_oe), 0);
        chk("tmo_dir_kept", int'(bus_dir), 1);
        resp_en = 1'b1;
        resp_cap = 8'h00;
        do_cmd(1'b1, 8'h3D, 1'b0, lat, d, e, dc, oc, sc, r0);
        chk("post_tmo_latency", lat, 11);
        chk("post_tmo_err_clear", int'(e), 0);
        chk("post_tmo_wr_captured", int'(resp_cap), 8'h3D);
`endif

        repeat (3) @(negedge clk);
        chk("rsp_pulse_count", rsp_pulses, n_cmds);
        chk("host_drive_while_dir0", dir_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
